// File: rtl/puf_eval_sequencer.sv
// rtl/puf_eval_sequencer.sv - TERO PUF group evaluation sequencer
// Walks the loop array one group of NUM_CHANNELS loops at a time in a
// challenge-permuted order, repeating each evaluation R times with an
// enable window of E cycles, and strobes the averaging block per result.
module puf_eval_sequencer #(
  parameter int NUM_LOOPS      = 16,
  parameter int NUM_CHANNELS   = 4,
  parameter int CHALLENGE_BITS = 8,
  parameter int EVAL_BITS      = 16,
  parameter int REP_BITS       = 16,
  localparam int NUM_GROUPS    = NUM_LOOPS / NUM_CHANNELS,
  localparam int SEL_W         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CHALLENGE_BITS-1:0] challenge,
  input  logic [EVAL_BITS-1:0]      eval_cycles,
  input  logic [REP_BITS-1:0]       repetitions,
  input  logic                      next_enable,
  output logic                      reset_puf,
  output logic                      enable_puf,
  output logic [SEL_W-1:0]          select_puf,
  output logic                      store_response,
  output logic                      store_last,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_error
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INIT      = 3'd1;
  localparam logic [2:0] EVAL      = 3'd2;
  localparam logic [2:0] STORE     = 3'd3;
  localparam logic [2:0] WAIT_NEXT = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [SEL_W-1:0] LAST_STEP = SEL_W'(NUM_GROUPS - 1);

  logic [2:0]           state;
  logic [SEL_W-1:0]     chal_sel;   // challenge bits that permute the group order
  logic [EVAL_BITS-1:0] eval_len;
  logic [REP_BITS-1:0]  rep_len;
  logic [SEL_W-1:0]     step;
  logic [REP_BITS-1:0]  rep;
  logic [EVAL_BITS-1:0] dly;
  logic                 cfg_err;
  logic                 last_rep;

  // Both length registers are non-zero whenever these compares are used,
  // so the minus-one never underflows and full-scale values need no wrap.
  assign last_rep = (rep == rep_len - REP_BITS'(1));

  // Sequencer state and counters; reset beats abort, abort beats every transition
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      chal_sel <= '0;
      eval_len <= '0;
      rep_len  <= '0;
      step     <= '0;
      rep      <= '0;
      dly      <= '0;
      cfg_err  <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      step    <= '0;
      rep     <= '0;
      dly     <= '0;
      cfg_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            chal_sel <= SEL_W'(challenge);
            eval_len <= eval_cycles;
            rep_len  <= repetitions;
            step     <= '0;
            rep      <= '0;
            dly      <= '0;
            if (eval_cycles == '0 || repetitions == '0) begin
              cfg_err <= 1'b1;
              state   <= DONE;
            end else begin
              state <= INIT;
            end
          end
        end
        INIT: begin
          dly   <= '0;
          state <= EVAL;
        end
        EVAL: begin
          if (dly == eval_len - EVAL_BITS'(1)) begin
            state <= STORE;
          end else begin
            dly <= dly + EVAL_BITS'(1);
          end
        end
        STORE: begin
          if (last_rep) begin
            rep   <= '0;
            state <= WAIT_NEXT;
          end else begin
            rep   <= rep + REP_BITS'(1);
            state <= INIT;
          end
        end
        WAIT_NEXT: begin
          if (next_enable) begin
            if (step == LAST_STEP) begin
              state <= DONE;
            end else begin
              step  <= step + SEL_W'(1);
              state <= INIT;
            end
          end
        end
        DONE: begin
          if (!start) begin
            cfg_err <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign reset_puf      = (state == INIT);
  assign enable_puf     = (state == EVAL);
  assign select_puf     = step ^ chal_sel;
  assign store_response = (state == STORE);
  assign store_last     = (state == STORE) && last_rep;
  assign busy           = (state != IDLE) && (state != DONE);
  assign done           = (state == DONE);
  assign cfg_error      = cfg_err;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// tb/tb_puf_eval_sequencer.sv - scoreboard bench for puf_eval_sequencer
module tb_puf_eval_sequencer;

  localparam int NL = 16;
  localparam int NC = 4;
  localparam int CB = 8;
  localparam int EB = 16;
  localparam int RB = 16;
  localparam int G  = NL / NC;
  localparam int SW = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CB-1:0] challenge;
  logic [EB-1:0] eval_cycles;
  logic [RB-1:0] repetitions;
  logic          next_enable;
  logic          reset_puf;
  logic          enable_puf;
  logic [SW-1:0] select_puf;
  logic          store_response;
  logic          store_last;
  logic          busy;
  logic          done;
  logic          cfg_error;

  puf_eval_sequencer #(
    .NUM_LOOPS(NL), .NUM_CHANNELS(NC), .CHALLENGE_BITS(CB),
    .EVAL_BITS(EB), .REP_BITS(RB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .challenge(challenge), .eval_cycles(eval_cycles),
    .repetitions(repetitions), .next_enable(next_enable),
    .reset_puf(reset_puf), .enable_puf(enable_puf), .select_puf(select_puf),
    .store_response(store_response), .store_last(store_last),
    .busy(busy), .done(done), .cfg_error(cfg_error)
  );

  typedef struct packed {
    logic [SW-1:0] sel;
    logic          last;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev_mon;
  int  n_cmp  = 0;
  int  n_bad  = 0;
  int  en_cnt = 0;
  int  cur_e  = 1;
  bit  rand_ne = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: every group once, in order step XOR challenge, R results each
  task automatic push_run(input int ch, input int r);
    ev_t ev;
    for (int g = 0; g < G; g++) begin
      for (int k = 0; k < r; k++) begin
        ev.sel  = SW'(g ^ (ch % G));
        ev.last = (k == r - 1);
        exp_q.push_back(ev);
      end
    end
  endtask

  // Monitor: score every store strobe and every enable window length
  always @(negedge clk) begin
    if (reset) begin
      en_cnt = 0;
    end else begin
      if (store_response) begin
        if (exp_q.size() == 0) begin
          check("store_unexpected", 1, 0);
        end else begin
          ev_mon = exp_q.pop_front();
          check("store_sel", select_puf, ev_mon.sel);
          check("store_last", store_last, ev_mon.last);
        end
      end else if (store_last) begin
        check("last_without_store", 1, 0);
      end
      if (enable_puf) begin
        en_cnt++;
      end else if (en_cnt > 0) begin
        if (busy) check("enable_len", en_cnt, cur_e);
        en_cnt = 0;
      end
    end
  end

  // Random back-pressure from the averaging block when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ne) next_enable = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_start();
    tick();
    start = 1'b0;
    tick();
    @(negedge clk);
    check("done_cleared", done, 0);
    check("cfg_error_cleared", cfg_error, 0);
  endtask

  task automatic do_run(input int ch, input int e, input int r, input bit timed);
    int cyc;
    int budget;
    tick();
    cur_e = e;
    push_run(ch, r);
    challenge   = CB'(ch);
    eval_cycles = EB'(e);
    repetitions = RB'(r);
    start       = 1'b1;
    tick();
    @(negedge clk);
    check("first_reset", reset_puf, 1);
    check("first_sel", select_puf, ch % G);
    budget = G * (r * (e + 2) + 1) + 400;
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1);
    if (timed) check("run_cycles", cyc, G * (r * (e + 2) + 1));
    check("queue_drained", exp_q.size(), 0);
    check("cfg_error_run", cfg_error, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int ch;
    int e;
    int r;
    reset = 1'b1; start = 1'b0; abort = 1'b0; challenge = '0;
    eval_cycles = '0; repetitions = '0; next_enable = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {reset_puf, enable_puf, select_puf, store_response, store_last, busy, done, cfg_error}, 0);

    // Directed group orders
    do_run(8'h00, 3, 2, 1'b1); drop_start();
    do_run(8'h02, 3, 2, 1'b1); drop_start();
    do_run(8'hFF, 3, 2, 1'b1); drop_start();
    do_run(8'h5A, 1, 1, 1'b1); drop_start();

    // Randomized configurations, some with back-pressure
    for (int i = 0; i < 6; i++) begin
      ch = $urandom_range(0, 255);
      e  = $urandom_range(1, 5);
      r  = $urandom_range(1, 3);
      rand_ne = (i % 2 == 1);
      do_run(ch, e, r, !rand_ne);
      rand_ne = 1'b0;
      next_enable = 1'b1;
      drop_start();
    end

    // WAIT_NEXT held off by the averaging block for 10 cycles
    tick();
    ch = $urandom_range(0, 255);
    cur_e = 3;
    push_run(ch, 2);
    next_enable = 1'b0;
    challenge = CB'(ch); eval_cycles = 3; repetitions = 2; start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(busy && !reset_puf && !enable_puf && !store_response) && cnt < 100);
    check("wait_next_reached", cnt < 100, 1);
    check("wait_hold", {select_puf, reset_puf, enable_puf, store_response}, {SW'(ch % G), 3'b000});
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("wait_hold", {select_puf, reset_puf, enable_puf, store_response}, {SW'(ch % G), 3'b000});
    end
    tick();
    next_enable = 1'b1;
    tick();
    @(negedge clk);
    check("release_init", reset_puf, 1);
    check("release_sel", select_puf, 1 ^ (ch % G));
    cnt = 0;
    while (!done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("wait_run_done", done, 1);
    check("wait_queue_drained", exp_q.size(), 0);
    drop_start();

    // Zero-length configurations are refused
    for (int k = 0; k < 2; k++) begin
      tick();
      eval_cycles = (k == 0) ? EB'(0) : EB'($urandom_range(1, 9));
      repetitions = (k == 0) ? RB'($urandom_range(1, 9)) : RB'(0);
      start = 1'b1;
      tick();
      @(negedge clk);
      check("cfg_done", done, 1);
      check("cfg_error_set", cfg_error, 1);
      check("cfg_no_puf", {reset_puf, enable_puf, busy}, 0);
      drop_start();
    end

    // Abort during group step 2
    tick();
    ch = $urandom_range(0, 255);
    cur_e = 3;
    push_run(ch, 2);
    challenge = CB'(ch); eval_cycles = 3; repetitions = 2; start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(enable_puf && select_puf == SW'(2 ^ (ch % G))) && cnt < 200);
    check("abort_point_reached", cnt < 200, 1);
    abort = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", {busy, enable_puf, store_response, reset_puf}, 0);
    exp_q.delete();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort_no_done", cnt, 0);
    do_run(ch, 2, 2, 1'b1); drop_start();

    // Reset while in STORE
    tick();
    cur_e = 2;
    push_run(8'h01, 3);
    challenge = 8'h01; eval_cycles = 2; repetitions = 3; start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!store_response && cnt < 100);
    #1;
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_store",
          {reset_puf, enable_puf, select_puf, store_response, store_last, busy, done, cfg_error}, 0);
    exp_q.delete();

    // start held through DONE must not retrigger
    do_run(8'h03, 2, 1, 1'b1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy || reset_puf || !done) cnt++;
    end
    check("no_retrigger", cnt, 0);
    drop_start();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
